// File: rtl/pll_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pll_seq_pkg : shared types and 27 MHz default timings for the PLL      |
// |               reset sequencer.                                        |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLLRST = 2'd0,
        WAIT   = 2'd1,
        STABLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    // 100 us stability window, 10 ms lock timeout, 1 us PLL reset pulse
    localparam int c_stable_cycles_27m  = 2700;
    localparam int c_lock_timeout_27m   = 270000;
    localparam int c_pll_rst_cycles_27m = 27;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_reset_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pll_reset_seq_if : PLL lock/reset and system-reset bundle.            |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
interface pll_reset_seq_if #(
    parameter int STAT_W = 8
);
    logic              lock;
    logic              pll_reset;
    logic              sys_reset_n;
    logic              ready;
    logic [STAT_W-1:0] retry_count;
    logic [STAT_W-1:0] loss_count;

    // The sequencer is the master; the PLL/status side is the slave.
    modport master (
        input  lock,
        output pll_reset,
        output sys_reset_n,
        output ready,
        output retry_count,
        output loss_count
    );

    modport slave (
        output lock,
        input  pll_reset,
        input  sys_reset_n,
        input  ready,
        input  retry_count,
        input  loss_count
    );
endinterface
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync2    : generic 2-FF synchronizer, synchronous active-low reset.   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module sync2 #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pll_reset_seq : pulses PLL RESET, qualifies LOCK and releases the     |
// |                 system reset; retries on timeout or lock loss.        |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int STABLE_CYCLES  = c_stable_cycles_27m,
    parameter int LOCK_TIMEOUT   = c_lock_timeout_27m,
    parameter int PLL_RST_CYCLES = c_pll_rst_cycles_27m,
    parameter int CNT_W          = $clog2(max3(STABLE_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES)) + 1,
    parameter int STAT_W         = 8
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    pll_reset_seq_if.master    seq_if
);
    localparam logic [CNT_W-1:0] c_pll_rst_last = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(STABLE_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pll_reset;
    logic              r_run;
    logic [STAT_W-1:0] r_retry_count;
    logic [STAT_W-1:0] r_loss_count;
    logic              w_lock_s;

    sync2 #(.WIDTH(1)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (seq_if.lock),
        .o_q     (w_lock_s)
    );

    // r_cnt is free to wrap while sitting in RUN; no decision there uses it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= PLLRST;
            r_cnt         <= '0;
            r_pll_reset   <= 1'b1;
            r_run         <= 1'b0;
            r_retry_count <= '0;
            r_loss_count  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            case (r_state)
                PLLRST: begin
                    if (r_cnt == c_pll_rst_last) begin
                        r_state     <= WAIT;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b0;
                    end
                end
                WAIT: begin
                    // A lock arriving on the timeout cycle takes priority.
                    if (w_lock_s) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_timeout_last) begin
                        r_state     <= PLLRST;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        if (r_retry_count != '1) begin
                            r_retry_count <= r_retry_count + 1'b1;
                        end
                    end
                end
                STABLE: begin
                    if (!w_lock_s) begin
                        r_state <= WAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_stable_last) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_run   <= 1'b1;
                    end
                end
                RUN: begin
                    if (!w_lock_s) begin
                        r_state     <= PLLRST;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        r_run       <= 1'b0;
                        if (r_loss_count != '1) begin
                            r_loss_count <= r_loss_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= PLLRST;
                    r_cnt       <= '0;
                    r_pll_reset <= 1'b1;
                    r_run       <= 1'b0;
                end
            endcase
        end
    end

    // ready and sys_reset_n share one flop so they can never disagree.
    assign seq_if.pll_reset   = r_pll_reset;
    assign seq_if.sys_reset_n = r_run;
    assign seq_if.ready       = r_run;
    assign seq_if.retry_count = r_retry_count;
    assign seq_if.loss_count  = r_loss_count;
endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pll_reset_seq : directed self-checking bench for pll_reset_seq.    |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
module tb_pll_reset_seq;
    import pll_seq_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;

    always #5 clk = ~clk;

    pll_reset_seq_if #(.STAT_W(8)) seq_if ();

    pll_reset_seq #(
        .STABLE_CYCLES  (8),
        .LOCK_TIMEOUT   (20),
        .PLL_RST_CYCLES (4),
        .STAT_W         (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .seq_if  (seq_if)
    );

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s (edge %0d): observed %0d, expected %0d", tag, edge_n, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
    endtask

    task automatic to_edge(input int e);
        while (edge_n < e) tick(1);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        edge_n  = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        seq_if.lock = 1'b1;

        // Cold lock followed by a loss in RUN
        apply_reset();
        check_eq("rst_pll_reset", int'(seq_if.pll_reset), 1);
        check_eq("rst_sys_reset_n", int'(seq_if.sys_reset_n), 0);
        check_eq("rst_ready", int'(seq_if.ready), 0);
        check_eq("rst_retry", int'(seq_if.retry_count), 0);
        check_eq("rst_loss", int'(seq_if.loss_count), 0);
        check_eq("rst_state", int'(dut.r_state), int'(PLLRST));
        to_edge(3);  check_eq("cold_pll_rst_e3", int'(seq_if.pll_reset), 1);
        to_edge(4);  check_eq("cold_pll_rst_e4", int'(seq_if.pll_reset), 0);
                     check_eq("cold_wait_e4", int'(dut.r_state), int'(WAIT));
        to_edge(5);  check_eq("cold_stable_e5", int'(dut.r_state), int'(STABLE));
        to_edge(12); check_eq("cold_sys_e12", int'(seq_if.sys_reset_n), 0);
        to_edge(13); check_eq("cold_sys_e13", int'(seq_if.sys_reset_n), 1);
                     check_eq("cold_ready_e13", int'(seq_if.ready), 1);
                     check_eq("cold_retry", int'(seq_if.retry_count), 0);
                     check_eq("cold_loss", int'(seq_if.loss_count), 0);

        to_edge(15); seq_if.lock = 1'b0;
        to_edge(17); check_eq("loss_sys_e17", int'(seq_if.sys_reset_n), 1);
        to_edge(18); check_eq("loss_sys_e18", int'(seq_if.sys_reset_n), 0);
                     check_eq("loss_pll_e18", int'(seq_if.pll_reset), 1);
                     check_eq("loss_ready_e18", int'(seq_if.ready), 0);
                     check_eq("loss_count1", int'(seq_if.loss_count), 1);
        seq_if.lock = 1'b1;
        to_edge(22); check_eq("loss_wait_e22", int'(dut.r_state), int'(WAIT));
                     check_eq("loss_pll_e22", int'(seq_if.pll_reset), 0);
        to_edge(23); check_eq("loss_stable_e23", int'(dut.r_state), int'(STABLE));
        to_edge(30); check_eq("loss_sys_e30", int'(seq_if.sys_reset_n), 0);
        to_edge(31); check_eq("loss_sys_e31", int'(seq_if.sys_reset_n), 1);

        // Two more losses, then a one-cycle reset while in RUN
        for (int i = 2; i <= 3; i++) begin
            seq_if.lock = 1'b0;
            tick(3);
            check_eq("loss_count_n", int'(seq_if.loss_count), i);
            check_eq("loss_sys_n", int'(seq_if.sys_reset_n), 0);
            seq_if.lock = 1'b1;
            tick(13);
            check_eq("loss_rerun_n", int'(seq_if.sys_reset_n), 1);
        end
        reset_n = 1'b0;
        tick(1);
        check_eq("mid_rst_pll", int'(seq_if.pll_reset), 1);
        check_eq("mid_rst_sys", int'(seq_if.sys_reset_n), 0);
        check_eq("mid_rst_ready", int'(seq_if.ready), 0);
        check_eq("mid_rst_loss", int'(seq_if.loss_count), 0);
        check_eq("mid_rst_retry", int'(seq_if.retry_count), 0);
        check_eq("mid_rst_state", int'(dut.r_state), int'(PLLRST));
        check_eq("mid_rst_cnt", int'(dut.r_cnt), 0);
        reset_n = 1'b1;

        // Two-cycle glitch while qualifying in STABLE
        seq_if.lock = 1'b1;
        apply_reset();
        to_edge(8);  check_eq("gl_stable_e8", int'(dut.r_state), int'(STABLE));
        seq_if.lock = 1'b0;
        to_edge(10); seq_if.lock = 1'b1;
        to_edge(11); check_eq("gl_wait_e11", int'(dut.r_state), int'(WAIT));
        to_edge(12); check_eq("gl_wait_e12", int'(dut.r_state), int'(WAIT));
        to_edge(13); check_eq("gl_stable_e13", int'(dut.r_state), int'(STABLE));
        to_edge(20); check_eq("gl_sys_e20", int'(seq_if.sys_reset_n), 0);
        to_edge(21); check_eq("gl_sys_e21", int'(seq_if.sys_reset_n), 1);
                     check_eq("gl_loss", int'(seq_if.loss_count), 0);

        // Lock arrives on the last WAIT cycle
        seq_if.lock = 1'b0;
        apply_reset();
        to_edge(21); seq_if.lock = 1'b1;
        to_edge(23); check_eq("sim_wait_e23", int'(dut.r_state), int'(WAIT));
                     check_eq("sim_cnt_e23", int'(dut.r_cnt), 19);
        to_edge(24); check_eq("sim_stable_e24", int'(dut.r_state), int'(STABLE));
                     check_eq("sim_retry", int'(seq_if.retry_count), 0);
                     check_eq("sim_pll_e24", int'(seq_if.pll_reset), 0);
        to_edge(31); check_eq("sim_sys_e31", int'(seq_if.sys_reset_n), 0);
        to_edge(32); check_eq("sim_sys_e32", int'(seq_if.sys_reset_n), 1);

        // No lock at all: retry every 24 edges, count saturates at 255
        seq_if.lock = 1'b0;
        apply_reset();
        for (int k = 1; k <= 257; k++) begin
            to_edge(24 * k - 1);
            check_eq("to_pll_low", int'(seq_if.pll_reset), 0);
            to_edge(24 * k);
            check_eq("to_pll_high", int'(seq_if.pll_reset), 1);
            check_eq("to_retry", int'(seq_if.retry_count), (k > 255) ? 255 : k);
            check_eq("to_sys", int'(seq_if.sys_reset_n), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset sequencer and lock supervisor at the consuming end of the rPLL clock/lock interface. It runs on the free-running 27 MHz board clock and pulses the PLL `RESET` input. It samples the asynchronous `lock` output and releases the system reset only after lock has been continuously stable. It reasserts system reset and retries the PLL whenever lock is lost or fails to appear within a timeout.

## Interface
Parameters:
- `STABLE_CYCLES`, 2700: consecutive synchronized-lock cycles required before release (100 µs at 27 MHz).
- `LOCK_TIMEOUT`, 270000: cycles to wait for lock after PLL reset before retrying (10 ms).
- `PLL_RST_CYCLES`, 27: width of the `pll_reset` pulse, in cycles.
- `CNT_W`, $clog2 of the largest of the three above, plus 1: shared counter width.
- `STAT_W`, 8: width of the statistics counters.

Ports:
- `clk`  in  1  free-running 27 MHz reference clock; never the PLL output.
- `reset_n`  in  1  synchronous, active-low reset.
- `lock`  in  1  PLL `LOCK` output; asynchronous to `clk`.
- `pll_reset`  out  1  drives PLL `RESET`; active high.
- `sys_reset_n`  out  1  active-low system reset for the 174 MHz domain; consumers resynchronize it.
- `ready`  out  1  high while in RUN; identical to `sys_reset_n`.
- `retry_count`  out  STAT_W  number of lock timeouts; saturates at all-ones.
- `loss_count`  out  STAT_W  number of lock losses while in RUN; saturates at all-ones.

## Operation
- `lock` passes through a 2-FF synchronizer, reset to 0. Its output is `lock_s`.
- One shared counter `cnt`. It is cleared on every state change and increments every cycle otherwise.
- States:
  - PLLRST: `pll_reset`=1. When `cnt`==PLL_RST_CYCLES-1, go to WAIT.
  - WAIT: if `lock_s`=1, go to STABLE. Otherwise, when `cnt`==LOCK_TIMEOUT-1, go to PLLRST and increment `retry_count`. If both occur on the same edge, `lock_s` wins.
  - STABLE: if `lock_s`=0, go to WAIT. Otherwise, when `cnt`==STABLE_CYCLES-1, go to RUN.
  - RUN: `sys_reset_n`=1 and `ready`=1. If `lock_s`=0, go to PLLRST and increment `loss_count`.
- The statistics counters are cleared only by `reset_n`.

## Timing
- All outputs are registered and change on the edge that performs the state transition.
- Reset values:
  - state PLLRST, `cnt`=0
  - `pll_reset`=1, `sys_reset_n`=0, `ready`=0
  - `retry_count`=0, `loss_count`=0
  - synchronizer stages 0
- `lock` to `lock_s` latency is 2 edges.
- A falling `lock` in RUN drives `sys_reset_n` low on the 3rd edge after the fall.
- A `lock` glitch of at least 1 cycle that reaches `lock_s` during STABLE restarts qualification from WAIT.
- A glitch that misses both synchronizer samples is ignored by design.
- `reset_n` low at any point, including mid-STABLE or in RUN, forces the reset values on that edge. This immediately asserts `pll_reset` and deasserts `ready`.

## Structure
- Package `pll_seq_pkg`:
  - `state_t` enum: PLLRST, WAIT, STABLE, RUN.
  - Default constants for the three cycle-count parameters at 27 MHz.
- Sub-module `sync2`: generic 2-FF synchronizer with synchronous active-low reset. It is reused by other clock-crossing paths.
- The top level holds the FSM, the shared counter and the saturating statistics counters.

## Test plan
All scenarios use STABLE_CYCLES=8, LOCK_TIMEOUT=20, PLL_RST_CYCLES=4. Edges are counted from the first edge with `reset_n`=1.

- **Cold lock.** `lock`=1 throughout. Required:
  - `pll_reset` high through edge 4, low after edge 4.
  - STABLE entered at edge 5.
  - `sys_reset_n`/`ready` rise at edge 13.
  - Both statistics counters stay 0.
- **Timeout retry.** `lock`=0 throughout. Required:
  - PLLRST re-entered every 24 edges.
  - `retry_count` increments each time and saturates at 255.
  - `sys_reset_n` never rises.
- **Glitch in STABLE.** `lock` low for 2 cycles at edge 9. Required:
  - Return to WAIT, then requalify.
  - `sys_reset_n` rises 8 edges after the re-entry into STABLE.
  - `loss_count`=0.
- **Loss in RUN.** Drop `lock` once in RUN. Required:
  - `sys_reset_n`=0 and `pll_reset`=1 on the 3rd edge after the drop.
  - `loss_count`=1.
  - Restoring `lock` re-releases after the full PLLRST→WAIT→STABLE sequence.
- **Simultaneous timeout and lock.** `lock_s` rises exactly on `cnt`==19 in WAIT. Required:
  - Next state STABLE.
  - `retry_count` unchanged.
- **Reset mid-operation.** `reset_n` low for 1 cycle while in RUN with `loss_count`=3. Required, on that edge:
  - all outputs at their reset values
  - counters 0.
